// File: rtl/cop0_exception_unit_pkg.sv
// cop0_pkg: COP0 register numbers, encodings, field positions and FSM states
package cop0_pkg;
    localparam logic [4:0] REG_STATUS = 5'd12;
    localparam logic [4:0] REG_CAUSE  = 5'd13;
    localparam logic [4:0] REG_EPC    = 5'd14;
    localparam logic [4:0] EXC_INT    = 5'd0;
    localparam logic [4:0] EXC_SYS    = 5'd8;
    localparam logic [4:0] RS_MF      = 5'b00000;
    localparam logic [4:0] RS_MT      = 5'b00100;
    localparam logic [4:0] RS_CO      = 5'b10000;
    localparam logic [5:0] ERET_FUNCT = 6'b011000;
    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;
    localparam int IM_LSB     = 8;
    localparam int IP_LSB     = 8;
    localparam int EXC_LSB    = 2;
    typedef enum logic {RUN, HANDLER} state_t;
endpackage

// File: rtl/cop0_exception_unit_if.sv
// cop0_exception_unit_if: retire/decode bus between the datapath and COP0
interface cop0_exception_unit_if;
    logic        instr_valid;
    logic [31:0] pc;
    logic        is_cop0;
    logic        is_syscall;
    logic [4:0]  cop0_rs;
    logic [4:0]  cop0_rd;
    logic [5:0]  funct;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        exl;
    modport master (
        output instr_valid, pc, is_cop0, is_syscall, cop0_rs, cop0_rd, funct, wdata,
        input  rdata, redirect, redirect_pc, flush, exl
    );
    modport slave (
        input  instr_valid, pc, is_cop0, is_syscall, cop0_rs, cop0_rd, funct, wdata,
        output rdata, redirect, redirect_pc, flush, exl
    );
endinterface

// File: rtl/cop0_exception_unit_irq_pending_latch.sv
// irq_pending_latch: edge-detects irq lines into sticky pending bits with write-1-to-clear
module irq_pending_latch #(
    parameter int IRQ_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IRQ_W-1:0] irq,
    input  logic [IRQ_W-1:0] clr,
    output logic [IRQ_W-1:0] ip
);
    logic [IRQ_W-1:0] irqPrev;
    // a rising edge sets a pending bit; an edge in the same cycle as its clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irqPrev <= '0;
            ip      <= '0;
        end else begin
            irqPrev <= irq;
            ip      <= (ip & ~clr) | (irq & ~irqPrev);
        end
    end
endmodule

// File: rtl/cop0_exception_unit.sv
// cop0_exception_unit: Status/Cause/EPC, syscall/interrupt entry, eret return and PC redirect
module cop0_exception_unit
    import cop0_pkg::*;
#(
    parameter int          IRQ_W      = 3,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IRQ_W-1:0]      irq,
    cop0_exception_unit_if.slave  bus
);
    state_t           state;
    logic             ie;
    logic [IRQ_W-1:0] im;
    logic [IRQ_W-1:0] ip;
    logic [IRQ_W-1:0] ipClr;
    logic [4:0]       excCode;
    logic [31:0]      epc;
    logic             redirect;
    logic [31:0]      redirectPc;
    logic             isMfc0;
    logic             isMtc0;
    logic             isEret;
    logic             intReq;
    logic             sysTake;
    logic             intTake;
    logic             eretTake;
    logic             mtWrite;
    logic [31:0]      statusVal;
    logic [31:0]      causeVal;

    irq_pending_latch #(.IRQ_W(IRQ_W)) uLatch (
        .clk   (clk),
        .rst_n (rst_n),
        .irq   (irq),
        .clr   (ipClr),
        .ip    (ip)
    );

    // decode and action priority: syscall > interrupt > eret > mtc0, all gated by a retire
    always_comb begin
        isMfc0    = bus.is_cop0 & (bus.cop0_rs == RS_MF);
        isMtc0    = bus.is_cop0 & (bus.cop0_rs == RS_MT);
        isEret    = bus.is_cop0 & (bus.cop0_rs == RS_CO) & (bus.funct == ERET_FUNCT);
        intReq    = ie & (state == RUN) & |(ip & im);
        sysTake   = bus.instr_valid & bus.is_syscall;
        intTake   = bus.instr_valid & ~bus.is_syscall & intReq;
        eretTake  = bus.instr_valid & ~bus.is_syscall & ~intTake & isEret & (state == HANDLER);
        mtWrite   = bus.instr_valid & ~bus.is_syscall & ~intTake & isMtc0;
        ipClr     = (mtWrite & (bus.cop0_rd == REG_CAUSE)) ? bus.wdata[IP_LSB +: IRQ_W] : '0;
        statusVal = 32'(ie) << STATUS_IE | 32'(state == HANDLER) << STATUS_EXL | 32'(im) << IM_LSB;
        causeVal  = 32'(ip) << IP_LSB | 32'(excCode) << EXC_LSB;
        bus.rdata = !isMfc0                    ? 32'd0 :
                    bus.cop0_rd == REG_STATUS  ? statusVal :
                    bus.cop0_rd == REG_CAUSE   ? causeVal :
                    bus.cop0_rd == REG_EPC     ? epc : 32'd0;
    end

    assign bus.flush       = intTake;
    assign bus.exl         = state == HANDLER;
    assign bus.redirect    = redirect;
    assign bus.redirect_pc = redirectPc;

    // RUN/HANDLER FSM with the COP0 registers and the registered redirect pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            ie         <= 1'b0;
            im         <= '0;
            excCode    <= EXC_INT;
            epc        <= 32'd0;
            redirect   <= 1'b0;
            redirectPc <= 32'd0;
        end else begin
            redirect <= sysTake | intTake | eretTake;
            if (sysTake | intTake)
                redirectPc <= EXC_VECTOR;
            else if (eretTake)
                redirectPc <= epc;
            if (sysTake) begin
                if (state == RUN)
                    epc <= bus.pc + 32'd4;
                excCode <= EXC_SYS;
                state   <= HANDLER;
            end else if (intTake) begin
                epc     <= bus.pc;
                excCode <= EXC_INT;
                state   <= HANDLER;
            end else if (eretTake) begin
                state <= RUN;
            end else if (mtWrite) begin
                if (bus.cop0_rd == REG_STATUS) begin
                    ie <= bus.wdata[STATUS_IE];
                    im <= bus.wdata[IM_LSB +: IRQ_W];
                end
                if (bus.cop0_rd == REG_EPC)
                    epc <= bus.wdata;
            end
        end
    end
endmodule

// File: tb/tb_cop0_exception_unit.sv
// tb_cop0_exception_unit: directed vector table, reset corner case and randomized model check
module tb_cop0_exception_unit;
    import cop0_pkg::*;
    localparam int          IRQ_W = 3;
    localparam logic [31:0] VEC   = 32'h8000_0180;
    localparam logic [31:0] P     = 32'h0040_0000;
    localparam int IDLE = 0, NOP = 1, SYS = 2, MF = 3, MT = 4, ER = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [IRQ_W-1:0] irq = '0;
    int               tests = 0;
    int               fails = 0;

    cop0_exception_unit_if bus();

    cop0_exception_unit #(.IRQ_W(IRQ_W), .EXC_VECTOR(VEC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .irq   (irq),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic        sys;
        logic        cop0;
        logic [4:0]  rs;
        logic [4:0]  rd;
        logic [5:0]  fn;
        logic [31:0] wd;
        logic [2:0]  irq;
        logic [31:0] pc;
        logic [31:0] eRd;
        logic        eFl;
        logic        eRe;
        logic [31:0] eRpc;
        logic        eExl;
    } vec_t;

    vec_t v[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int op, input logic [4:0] rd, input logic [31:0] wd,
                                input logic [2:0] iq, input logic [31:0] pc, input logic [31:0] eRd,
                                input logic eFl, input logic eRe, input logic [31:0] eRpc, input logic eExl);
        vec_t r;
        r.iv   = op != IDLE;
        r.sys  = op == SYS;
        r.cop0 = op >= MF;
        r.rs   = op == MF ? RS_MF : op == MT ? RS_MT : op == ER ? RS_CO : 5'd0;
        r.fn   = op == ER ? ERET_FUNCT : 6'd0;
        r.rd   = rd;
        r.wd   = wd;
        r.irq  = iq;
        r.pc   = pc;
        r.eRd  = eRd;
        r.eFl  = eFl;
        r.eRe  = eRe;
        r.eRpc = eRpc;
        r.eExl = eExl;
        return r;
    endfunction

    task automatic drive(input vec_t x);
        bus.instr_valid = x.iv;
        bus.is_syscall  = x.sys;
        bus.is_cop0     = x.cop0;
        bus.cop0_rs     = x.rs;
        bus.cop0_rd     = x.rd;
        bus.funct       = x.fn;
        bus.wdata       = x.wd;
        bus.pc          = x.pc;
        irq             = x.irq;
    endtask

    // behavioural reference state for the random phase
    bit        mIe, mExl, mRed;
    bit [2:0]  mIm, mIp, mPrev;
    bit [4:0]  mExc;
    bit [31:0] mEpc, mRpc;

    initial begin
        drive(mk(IDLE, 0, 0, 0, P, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_redirect", {31'd0, bus.redirect}, 32'd0);
        chk("reset_redirect_pc", bus.redirect_pc, 32'd0);
        chk("reset_exl", {31'd0, bus.exl}, 32'd0);

        v.push_back(mk(MF, 12, 0, 0, P, 0, 0, 0, 0, 0));
        v.push_back(mk(MF, 13, 0, 0, P, 0, 0, 0, 0, 0));
        v.push_back(mk(MF, 14, 0, 0, P, 0, 0, 0, 0, 0));
        v.push_back(mk(SYS, 0, 0, 0, 32'h0040_0010, 0, 0, 1, VEC, 1));
        v.push_back(mk(MF, 14, 0, 0, P, 32'h0040_0014, 0, 0, VEC, 1));
        v.push_back(mk(MF, 13, 0, 0, P, 32'h20, 0, 0, VEC, 1));
        v.push_back(mk(MF, 12, 0, 0, P, 32'h2, 0, 0, VEC, 1));
        v.push_back(mk(ER, 0, 0, 0, P, 0, 0, 1, 32'h0040_0014, 0));
        v.push_back(mk(MT, 12, 32'h101, 0, P, 0, 0, 0, 32'h0040_0014, 0));
        v.push_back(mk(IDLE, 0, 0, 1, P, 0, 0, 0, 32'h0040_0014, 0));
        v.push_back(mk(NOP, 0, 0, 1, 32'h0040_0020, 0, 1, 1, VEC, 1));
        v.push_back(mk(MF, 14, 0, 1, P, 32'h0040_0020, 0, 0, VEC, 1));
        v.push_back(mk(MF, 13, 0, 1, P, 32'h100, 0, 0, VEC, 1));
        v.push_back(mk(MT, 13, 32'h100, 1, P, 0, 0, 0, VEC, 1));
        v.push_back(mk(MF, 13, 0, 1, P, 0, 0, 0, VEC, 1));
        v.push_back(mk(ER, 0, 0, 1, P, 0, 0, 1, 32'h0040_0020, 0));
        v.push_back(mk(ER, 0, 0, 1, P, 0, 0, 0, 32'h0040_0020, 0));
        v.push_back(mk(IDLE, 0, 0, 3, P, 0, 0, 0, 32'h0040_0020, 0));
        v.push_back(mk(NOP, 0, 0, 3, P, 0, 0, 0, 32'h0040_0020, 0));
        v.push_back(mk(MF, 13, 0, 3, P, 32'h200, 0, 0, 32'h0040_0020, 0));
        v.push_back(mk(MT, 12, 32'h201, 3, P, 0, 0, 0, 32'h0040_0020, 0));
        v.push_back(mk(NOP, 0, 0, 3, 32'h0040_0030, 0, 1, 1, VEC, 1));
        v.push_back(mk(MF, 14, 0, 3, P, 32'h0040_0030, 0, 0, VEC, 1));
        v.push_back(mk(MT, 13, 32'h200, 3, P, 0, 0, 0, VEC, 1));
        v.push_back(mk(ER, 0, 0, 3, P, 0, 0, 1, 32'h0040_0030, 0));
        v.push_back(mk(IDLE, 0, 0, 1, P, 0, 0, 0, 32'h0040_0030, 0));
        v.push_back(mk(IDLE, 0, 0, 3, P, 0, 0, 0, 32'h0040_0030, 0));
        v.push_back(mk(SYS, 0, 0, 3, 32'h0040_0040, 0, 0, 1, VEC, 1));
        v.push_back(mk(MF, 13, 0, 3, P, 32'h220, 0, 0, VEC, 1));
        v.push_back(mk(MF, 14, 0, 3, P, 32'h0040_0044, 0, 0, VEC, 1));
        v.push_back(mk(ER, 0, 0, 3, P, 0, 0, 1, 32'h0040_0044, 0));
        v.push_back(mk(NOP, 0, 0, 3, 32'h0040_0044, 0, 1, 1, VEC, 1));
        v.push_back(mk(MF, 13, 0, 3, P, 32'h200, 0, 0, VEC, 1));
        v.push_back(mk(IDLE, 0, 0, 7, P, 0, 0, 0, VEC, 1));
        v.push_back(mk(IDLE, 0, 0, 3, P, 0, 0, 0, VEC, 1));
        v.push_back(mk(MT, 13, 32'h400, 7, P, 0, 0, 0, VEC, 1));
        v.push_back(mk(MF, 13, 0, 7, P, 32'h600, 0, 0, VEC, 1));

        for (int i = 0; i < v.size(); i++) begin
            drive(v[i]);
            @(negedge clk);
            chk($sformatf("v%0d_rdata", i), bus.rdata, v[i].eRd);
            chk($sformatf("v%0d_flush", i), {31'd0, bus.flush}, {31'd0, v[i].eFl});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_redirect", i), {31'd0, bus.redirect}, {31'd0, v[i].eRe});
            chk($sformatf("v%0d_redirect_pc", i), bus.redirect_pc, v[i].eRpc);
            chk($sformatf("v%0d_exl", i), {31'd0, bus.exl}, {31'd0, v[i].eExl});
        end

        // reset pulsed mid-handler with a syscall retiring: everything clears, no redirect
        drive(mk(SYS, 0, 0, 7, 32'h0040_0050, 0, 0, 0, 0, 0));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_exl", {31'd0, bus.exl}, 32'd0);
        chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_redirect_dropped", {31'd0, bus.redirect}, 32'd0);
        drive(mk(MF, 13, 0, 0, P, 0, 0, 0, 0, 0));
        #1 chk("rst_cause", bus.rdata, 32'd0);
        drive(mk(MF, 14, 0, 0, P, 0, 0, 0, 0, 0));
        #1 chk("rst_epc", bus.rdata, 32'd0);
        drive(mk(MF, 12, 0, 0, P, 0, 0, 0, 0, 0));
        #1 chk("rst_status", bus.rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // randomized phase against a rule-level model
        mIe = 0; mExl = 0; mRed = 0; mIm = 0; mIp = 0; mPrev = 0; mExc = 0; mEpc = 0; mRpc = 0;
        for (int n = 0; n < 3000; n++) begin
            int op, rsel, act;
            bit mfc, mtc, er, pend;
            bit [2:0] clr, edges;
            bit [31:0] expRd, statusV, causeV;
            op   = $urandom_range(0, 9);
            rsel = $urandom_range(0, 3);
            bus.instr_valid = op != 0;
            bus.is_syscall  = op == 3;
            bus.is_cop0     = op >= 4;
            bus.cop0_rs     = (op == 4 || op == 5) ? 5'b00000 : (op == 6 || op == 7) ? 5'b00100 : 5'b10000;
            bus.funct       = op == 9 ? 6'($urandom_range(0, 63)) : 6'b011000;
            bus.cop0_rd     = rsel == 0 ? 5'd12 : rsel == 1 ? 5'd13 : rsel == 2 ? 5'd14 : 5'($urandom);
            bus.wdata       = $urandom;
            bus.pc          = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0)
                irq = 3'($urandom_range(0, 7));
            mfc = bus.is_cop0 && bus.cop0_rs == 5'd0;
            mtc = bus.is_cop0 && bus.cop0_rs == 5'd4;
            er  = bus.is_cop0 && bus.cop0_rs == 5'd16 && bus.funct == 6'd24;
            statusV = mIe + 2 * mExl + 256 * mIm;
            causeV  = 256 * mIp + 4 * mExc;
            expRd = !mfc ? 0 : bus.cop0_rd == 12 ? statusV : bus.cop0_rd == 13 ? causeV :
                    bus.cop0_rd == 14 ? mEpc : 0;
            pend = mIe && !mExl && (mIp & mIm) != 0;
            act = !bus.instr_valid ? 0 : bus.is_syscall ? 1 : pend ? 2 : (er && mExl) ? 3 : mtc ? 4 : 0;
            #3;
            chk($sformatf("r%0d_rdata", n), bus.rdata, expRd);
            chk($sformatf("r%0d_flush", n), {31'd0, bus.flush}, act == 2 ? 32'd1 : 32'd0);
            edges = irq & ~mPrev;
            clr   = (act == 4 && bus.cop0_rd == 13) ? bus.wdata[10:8] : 3'd0;
            mRed  = act >= 1 && act <= 3;
            if (act == 1) begin
                if (!mExl) mEpc = bus.pc + 4;
                mExc = 8; mExl = 1; mRpc = VEC;
            end else if (act == 2) begin
                mEpc = bus.pc; mExc = 0; mExl = 1; mRpc = VEC;
            end else if (act == 3) begin
                mRpc = mEpc; mExl = 0;
            end else if (act == 4) begin
                if (bus.cop0_rd == 12) begin mIe = bus.wdata[0]; mIm = bus.wdata[10:8]; end
                if (bus.cop0_rd == 14) mEpc = bus.wdata;
            end
            mIp   = (mIp & ~clr) | edges;
            mPrev = irq;
            @(posedge clk);
            #1;
            chk($sformatf("r%0d_redirect", n), {31'd0, bus.redirect}, {31'd0, mRed});
            chk($sformatf("r%0d_redirect_pc", n), bus.redirect_pc, mRpc);
            chk($sformatf("r%0d_exl", n), {31'd0, bus.exl}, {31'd0, mExl});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
